tc_pl_adc_merge: RTL and testbench

Upstream feeder of the capture data stage. Takes the 14-bit ADC sample stream and, on a capture trigger, skips a programmed delay. It then packs 4 consecutive samples into each 56-bit word, for a programmed number of words per frame. Words are buffered in a small FIFO and presented on the Gc_merge_data / Gc_mereg_datv / Gc_mereg_datr valid/ready interface consumed by the capture data stage.

---
 rtl/tc_pl_adc_merge.sv | 157 +++++++++++++++
 tb/tb_tc_pl_adc_merge.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_pl_adc_merge.sv
// ADC sample merger: packs four 14-bit samples per word after a triggered delay and buffers them in a FWFT FIFO.
// Optional build macro TC_ADC_MERGE_TESTPAT_EN adds cfg_testpat, which substitutes a sample ramp for adc_data.
module tc_pl_adc_merge #(
   parameter int ADC_W   = 14,
   parameter int ADC0_1  = 56,
   parameter int PTS_W   = 14,
   parameter int DLY_W   = 16,
   parameter int FIFO_AW = 4
) (
   input  logic              clk125,
   input  logic              rst,
   input  logic [ADC_W-1:0]  adc_data,
   input  logic              adc_valid,
   input  logic [PTS_W-1:0]  cfg_points,
   input  logic [DLY_W-1:0]  cfg_delay,
   input  logic              Gc_cap_trig,
`ifdef TC_ADC_MERGE_TESTPAT_EN
   input  logic              cfg_testpat,
`endif
   output logic              Gc_capr_rdy,
   output logic [ADC0_1-1:0] Gc_merge_data,
   output logic              Gc_mereg_datv,
   input  logic              Gc_mereg_datr,
   output logic              merge_busy,
   output logic              merge_ovf,
   input  logic              merge_ovf_clr
);

   localparam int DEPTH = 2 ** FIFO_AW;

   typedef enum logic [1:0] {IDLE, DELAY, PACK} state_t;

   state_t               state, state_n;
   logic                 started;
   logic [PTS_W-1:0]     pts_q, words_done, words_done_n;
   logic [DLY_W-1:0]     dly_cnt;
   logic [1:0]           lane;
   logic [3*ADC_W-1:0]   acc;
   logic [ADC_W-1:0]     sample;
   logic                 trig_ok, take, push;
   logic [ADC0_1-1:0]    push_word;

   logic [ADC0_1-1:0]    mem [DEPTH];
   logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
   logic [FIFO_AW:0]     count;
   logic [ADC0_1-1:0]    last_q;
   logic                 full, pop, wr_en;

   // Triggers are only honoured once the block has seen a clock edge out of reset.
   assign trig_ok      = Gc_cap_trig && started && (state == IDLE);
   assign take         = (state == PACK) && adc_valid;
   assign push         = take && (lane == 2'd3);
   assign push_word    = {sample, acc};
   assign words_done_n = words_done + PTS_W'(1);

   assign Gc_capr_rdy  = started && (state == IDLE);
   assign merge_busy   = (state != IDLE);

`ifdef TC_ADC_MERGE_TESTPAT_EN
   logic             tp_q;
   logic [ADC_W-1:0] ramp;

   always_ff @(posedge clk125 or negedge rst) begin
      if (!rst) begin
         tp_q <= 1'b0;
         ramp <= '0;
      end else if (trig_ok) begin
         tp_q <= cfg_testpat;
         ramp <= '0;
      end else if (take) begin
         ramp <= ramp + ADC_W'(1);
      end
   end

   assign sample = tp_q ? ramp : adc_data;
`else
   assign sample = adc_data;
`endif

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (trig_ok && (cfg_points != '0))
                     state_n = (cfg_delay == '0) ? PACK : DELAY;
         DELAY:   if (dly_cnt == DLY_W'(1)) state_n = PACK;
         PACK:    if (push && (words_done_n == pts_q)) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Frame control and lane packing; the 4th sample bypasses acc straight into the pushed word.
   always_ff @(posedge clk125 or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         started    <= 1'b0;
         pts_q      <= '0;
         words_done <= '0;
         dly_cnt    <= '0;
         lane       <= '0;
         acc        <= '0;
      end else begin
         state   <= state_n;
         started <= 1'b1;
         if (trig_ok) begin
            pts_q      <= cfg_points;
            dly_cnt    <= cfg_delay;
            words_done <= '0;
            lane       <= '0;
         end else if (state == DELAY) begin
            dly_cnt <= dly_cnt - DLY_W'(1);
         end else if (take) begin
            if (lane == 2'd3) begin
               lane       <= '0;
               words_done <= words_done_n;
            end else begin
               lane                      <= lane + 2'd1;
               acc[lane*ADC_W +: ADC_W]  <= sample;
            end
         end
      end
   end

   assign full          = (count == (FIFO_AW+1)'(DEPTH));
   assign pop           = (count != '0) && Gc_mereg_datr;
   assign wr_en         = push && !full;
   assign Gc_mereg_datv = (count != '0);
   assign Gc_merge_data = (count != '0) ? mem[rd_ptr] : last_q;

   always_ff @(posedge clk125) begin
      if (wr_en) mem[wr_ptr] <= push_word;
   end

   // Occupancy bookkeeping; a push into a full FIFO is dropped even if a pop frees a slot this cycle.
   always_ff @(posedge clk125 or negedge rst) begin
      if (!rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         last_q    <= '0;
         merge_ovf <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + FIFO_AW'(1);
         if (pop) begin
            rd_ptr <= rd_ptr + FIFO_AW'(1);
            last_q <= mem[rd_ptr];
         end
         case ({wr_en, pop})
            2'b10:   count <= count + (FIFO_AW+1)'(1);
            2'b01:   count <= count - (FIFO_AW+1)'(1);
            default: count <= count;
         endcase
         if (push && full)      merge_ovf <= 1'b1;
         else if (merge_ovf_clr) merge_ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tc_pl_adc_merge.sv
// Self-checking bench for tc_pl_adc_merge: directed frames plus random traffic against a queue-based frame model.
module tb_tc_pl_adc_merge;

   logic        clk125 = 1'b0;
   logic        rst = 1'b0;
   logic [13:0] adc_data = '0;
   logic        adc_valid = 1'b0;
   logic [13:0] cfg_points = '0;
   logic [15:0] cfg_delay = '0;
   logic        Gc_cap_trig = 1'b0;
   logic        Gc_capr_rdy;
   logic [55:0] Gc_merge_data;
   logic        Gc_mereg_datv;
   logic        Gc_mereg_datr = 1'b0;
   logic        merge_busy;
   logic        merge_ovf;
   logic        merge_ovf_clr = 1'b0;

   int total = 0;
   int bad = 0;
   int rdy_low = 0;
   int obs_pops = 0;

   // Reference model: a frame is "skip N cycles, then gather 4*points valid samples"; words queue in a 16-deep list.
   logic [55:0] m_q[$];
   logic [13:0] m_cur[$];
   logic [55:0] m_last;
   bit          m_started, m_active, m_ovf;
   int          m_skip, m_need;

   always #4 clk125 = ~clk125;

   tc_pl_adc_merge dut (
      .clk125        (clk125),
      .rst           (rst),
      .adc_data      (adc_data),
      .adc_valid     (adc_valid),
      .cfg_points    (cfg_points),
      .cfg_delay     (cfg_delay),
      .Gc_cap_trig   (Gc_cap_trig),
`ifdef TC_ADC_MERGE_TESTPAT_EN
      .cfg_testpat   (1'b0),
`endif
      .Gc_capr_rdy   (Gc_capr_rdy),
      .Gc_merge_data (Gc_merge_data),
      .Gc_mereg_datv (Gc_mereg_datv),
      .Gc_mereg_datr (Gc_mereg_datr),
      .merge_busy    (merge_busy),
      .merge_ovf     (merge_ovf),
      .merge_ovf_clr (merge_ovf_clr)
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      m_q.delete();
      m_cur.delete();
      m_last    = '0;
      m_started = 0;
      m_active  = 0;
      m_ovf     = 0;
      m_skip    = 0;
      m_need    = 0;
   endtask

   task automatic modelEdge();
      int          pre;
      bit          have_w;
      logic [55:0] w;
      pre    = m_q.size();
      have_w = 0;
      w      = '0;
      if (m_active) begin
         if (m_skip > 0) m_skip--;
         else if (adc_valid) begin
            m_cur.push_back(adc_data);
            if (m_cur.size() == 4) begin
               w      = {m_cur[3], m_cur[2], m_cur[1], m_cur[0]};
               have_w = 1;
               m_cur.delete();
               m_need--;
               if (m_need == 0) m_active = 0;
            end
         end
      end else if (m_started && Gc_cap_trig && cfg_points != 0) begin
         m_active = 1;
         m_skip   = int'(cfg_delay);
         m_need   = int'(cfg_points);
         m_cur.delete();
      end
      if (pre != 0 && Gc_mereg_datr) m_last = m_q.pop_front();
      if (have_w && pre == 16) m_ovf = 1;
      else if (merge_ovf_clr) m_ovf = 0;
      if (have_w && pre != 16) m_q.push_back(w);
      m_started = 1;
   endtask

   // One clock: compare against the model, drive the next inputs, then advance the model on the edge.
   task automatic applyStimulus(input bit trig, input int pts, input int dly, input bit valid,
                                input logic [13:0] data, input bit datr, input bit clr);
      @(negedge clk125);
      checkOutput("datv", Gc_mereg_datv, m_q.size() != 0);
      checkOutput("data", Gc_merge_data, (m_q.size() != 0) ? m_q[0] : m_last);
      checkOutput("rdy", Gc_capr_rdy, m_started && !m_active);
      checkOutput("busy", merge_busy, m_active);
      checkOutput("ovf", merge_ovf, m_ovf);
      Gc_cap_trig   = trig;
      cfg_points    = 14'(pts);
      cfg_delay     = 16'(dly);
      adc_valid     = valid;
      adc_data      = data;
      Gc_mereg_datr = datr;
      merge_ovf_clr = clr;
      if (!Gc_capr_rdy) rdy_low++;
      if (Gc_mereg_datv && datr) obs_pops++;
      @(posedge clk125);
      modelEdge();
   endtask

   task automatic doReset();
      @(negedge clk125);
      rst = 1'b0;
      #1;
      checkOutput("rst_datv", Gc_mereg_datv, 0);
      checkOutput("rst_data", Gc_merge_data, 0);
      checkOutput("rst_rdy", Gc_capr_rdy, 0);
      checkOutput("rst_busy", merge_busy, 0);
      checkOutput("rst_ovf", merge_ovf, 0);
      modelReset();
      Gc_cap_trig   = 0;
      adc_valid     = 0;
      Gc_mereg_datr = 0;
      merge_ovf_clr = 0;
      repeat (3) @(posedge clk125);
      @(negedge clk125);
      rst = 1'b1;
      @(posedge clk125);
      modelEdge();
   endtask

   task automatic drain();
      for (int i = 0; i < 40; i++) begin
         applyStimulus(0, 0, 0, 0, 14'd0, 1, 0);
         #1;
         if (!Gc_mereg_datv) break;
      end
      checkOutput("drain_done", Gc_mereg_datv, 0);
   endtask

   initial begin
      modelReset();

      // Two words from samples 1..8, no delay, consumer stalled
      doReset();
      rdy_low = 0;
      applyStimulus(1, 2, 0, 1, 14'h3fff, 0, 0);
      for (int i = 1; i <= 8; i++) applyStimulus(0, 0, 0, 1, 14'(i), 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 14'd0, 0, 0);
      checkOutput("rdy_low8", rdy_low, 8);
      #1;
      checkOutput("word0", Gc_merge_data, {14'd4, 14'd3, 14'd2, 14'd1});
      applyStimulus(0, 0, 0, 0, 14'd0, 1, 0);
      #1;
      checkOutput("word1", Gc_merge_data, {14'd8, 14'd7, 14'd6, 14'd5});
      checkOutput("ovf_clean", merge_ovf, 0);
      drain();

      // Delay of 5: samples at T+1..T+5 skipped, word from T+6..T+9
      applyStimulus(1, 1, 5, 1, 14'd100, 0, 0);
      for (int k = 1; k <= 12; k++) applyStimulus(0, 0, 0, 1, 14'(100 + k), 0, 0);
      #1;
      checkOutput("delay_word", Gc_merge_data, {14'd109, 14'd108, 14'd107, 14'd106});
      drain();

      // 20 words into a stalled 16-deep FIFO: four dropped, overflow sticky
      applyStimulus(1, 20, 0, 1, 14'd0, 0, 0);
      for (int i = 0; i < 80; i++) applyStimulus(0, 0, 0, 1, 14'($urandom()), 0, 0);
      applyStimulus(0, 0, 0, 0, 14'd0, 0, 0);
      #1;
      checkOutput("ovf_set", merge_ovf, 1);
      obs_pops = 0;
      drain();
      checkOutput("drained16", obs_pops, 16);
      checkOutput("ovf_sticky", merge_ovf, 1);

      // Push at full coinciding with a pop and an overflow clear: drop wins
      applyStimulus(0, 0, 0, 0, 14'd0, 0, 1);
      applyStimulus(1, 16, 0, 1, 14'd0, 0, 0);
      for (int i = 0; i < 64; i++) applyStimulus(0, 0, 0, 1, 14'($urandom()), 0, 0);
      applyStimulus(1, 1, 0, 0, 14'd0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 14'(i + 1), 0, 0);
      applyStimulus(0, 0, 0, 1, 14'd4, 1, 1);
      applyStimulus(0, 0, 0, 0, 14'd0, 0, 0);
      #1;
      checkOutput("ovf_full_pop", merge_ovf, 1);
      obs_pops = 0;
      drain();
      checkOutput("drained15", obs_pops, 15);

      // Zero-point trigger and retrigger while busy are both ignored
      applyStimulus(1, 0, 3, 1, 14'd5, 0, 0);
      applyStimulus(0, 0, 0, 1, 14'd6, 0, 0);
      #1;
      checkOutput("pts0_rdy", Gc_capr_rdy, 1);
      checkOutput("pts0_datv", Gc_mereg_datv, 0);
      applyStimulus(1, 2, 2, 1, 14'd0, 0, 0);
      for (int i = 0; i < 14; i++)
         applyStimulus(i == 4, 5, 0, 1, 14'($urandom()), 0, 0);
      for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 14'($urandom()), 0, 0);
      obs_pops = 0;
      drain();
      checkOutput("retrig_words", obs_pops, 2);

      // Reset mid-frame with three buffered words and a partial word
      applyStimulus(1, 10, 0, 1, 14'd0, 0, 0);
      for (int i = 0; i < 14; i++) applyStimulus(0, 0, 0, 1, 14'(200 + i), 0, 0);
      doReset();
      applyStimulus(1, 1, 0, 0, 14'd0, 0, 0);
      applyStimulus(0, 0, 0, 1, 14'd11, 0, 0);
      applyStimulus(0, 0, 0, 1, 14'd22, 0, 0);
      applyStimulus(0, 0, 0, 1, 14'd33, 0, 0);
      applyStimulus(0, 0, 0, 1, 14'd44, 0, 0);
      applyStimulus(0, 0, 0, 0, 14'd0, 0, 0);
      #1;
      checkOutput("post_rst_word", Gc_merge_data, {14'd44, 14'd33, 14'd22, 14'd11});
      drain();

      // Random traffic: toggling valid/ready, random triggers, occasional clears
      for (int i = 0; i < 2000; i++) begin
         applyStimulus(($urandom() % 16) == 0, int'($urandom_range(0, 5)), int'($urandom_range(0, 6)),
                       (i % 4 < 2) ? ((i % 2) == 0) : $urandom_range(0, 1) == 1,
                       14'($urandom()), $urandom_range(0, 2) != 0, ($urandom() % 40) == 0);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
